// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: N data bits, optional parity, 1/2 stop bits,
// input synchroniser, 3-sample majority vote, glitch rejection and break hold-off.
module uart_rx_cfg #(
    parameter int unsigned CLK_FREQ  = 300000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_serial,
    output logic [DATA_BITS-1:0] o_rx_bus,
    output logic                 o_rx_valid,
    output logic                 o_rx_active,
    output logic                 o_parity_err,
    output logic                 o_frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HM1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_H    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_HP1  = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, rx_s_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [1:0]           samp_q, samp_d;
    logic                 err_p_q, err_p_d;
    logic                 err_f_q, err_f_d;
    logic [DATA_BITS-1:0] bus_q, bus_d;
    logic                 valid_q, valid_d;
    logic                 active_q, active_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    logic vote_c;
    logic exp_par_c;
    logic ferr_c;

    // Majority of the samples taken at HALF-1, HALF and the current one at HALF+1
    assign vote_c    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign exp_par_c = (PARITY == 1) ? ~(^data_q) : (^data_q);
    assign ferr_c    = err_f_q | ~vote_c;

    // Two-flop synchroniser for the asynchronous line, idles high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx_serial;
            rx_s_q  <= sync1_q;
        end
    end

    // State, counters and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            samp_q     <= 2'b11;
            err_p_q    <= 1'b0;
            err_f_q    <= 1'b0;
            bus_q      <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            samp_q     <= samp_d;
            err_p_q    <= err_p_d;
            err_f_q    <= err_f_d;
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state, bit sampling and word delivery
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        samp_d     = samp_q;
        err_p_d    = err_p_q;
        err_f_d    = err_f_q;
        bus_d      = bus_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;

        if (cnt_q == CNT_HM1) samp_d[0] = rx_s_q;
        if (cnt_q == CNT_H)   samp_d[1] = rx_s_q;

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                err_p_d    = 1'b0;
                err_f_d    = 1'b0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HP1 && vote_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_HP1) data_d = {vote_c, data_q[DATA_BITS-1:1]};
                if (cnt_q == CNT_LAST) begin
                    if (bit_idx_q < IDX_LAST) bit_idx_d = bit_idx_q + IDX_W'(1);
                    else                      state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_HP1)  err_p_d = (vote_c != exp_par_c);
                if (cnt_q == CNT_LAST) state_d = S_STOP;
            end
            S_STOP: begin
                if (cnt_q == CNT_HP1) begin
                    err_f_d = ferr_c;
                    if (stop_idx_q == STOP_LAST) begin
                        // Deliver at mid final stop bit so the next start edge is caught
                        valid_d = 1'b1;
                        bus_d   = data_q;
                        perr_d  = err_p_q;
                        ferr_d  = ferr_c;
                        cnt_d   = '0;
                        state_d = ferr_c ? S_BREAK : S_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    stop_idx_d = 1'b1;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        active_d = (state_d == S_START) || (state_d == S_DATA) ||
                   (state_d == S_PARITY) || (state_d == S_STOP);
    end

    assign o_rx_bus     = bus_q;
    assign o_rx_valid   = valid_q;
    assign o_rx_active  = active_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg with a per-instance scoreboard of expected words.
module tb_uart_rx_cfg;

    localparam int unsigned CPB = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

    always #5 clk = ~clk;

    logic [7:0] a_bus, b_bus;
    logic [6:0] c_bus;
    logic a_valid, a_active, a_perr, a_ferr;
    logic b_valid, b_active, b_perr, b_ferr;
    logic c_valid, c_active, c_perr, c_ferr;

    // 8N1
    uart_rx_cfg #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx0), .o_rx_bus(a_bus), .o_rx_valid(a_valid),
        .o_rx_active(a_active), .o_parity_err(a_perr), .o_frame_err(a_ferr));
    // 8E1
    uart_rx_cfg #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx1), .o_rx_bus(b_bus), .o_rx_valid(b_valid),
        .o_rx_active(b_active), .o_parity_err(b_perr), .o_frame_err(b_ferr));
    // 7O2
    uart_rx_cfg #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx2), .o_rx_bus(c_bus), .o_rx_valid(c_valid),
        .o_rx_active(c_active), .o_parity_err(c_perr), .o_frame_err(c_ferr));

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int tests = 0;
    int fails = 0;
    int pulses0 = 0, pulses1 = 0, pulses2 = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop and compare on every delivered word
    always @(negedge clk) begin
        if (a_valid) begin
            pulses0++;
            check("a_pulse_expected", 16'(q0.size() > 0), 16'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                check("a_bus", 16'(a_bus), 16'(e0.data));
                check("a_perr", 16'(a_perr), 16'(e0.perr));
                check("a_ferr", 16'(a_ferr), 16'(e0.ferr));
            end
        end
        if (b_valid) begin
            pulses1++;
            check("b_pulse_expected", 16'(q1.size() > 0), 16'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("b_bus", 16'(b_bus), 16'(e1.data));
                check("b_perr", 16'(b_perr), 16'(e1.perr));
                check("b_ferr", 16'(b_ferr), 16'(e1.ferr));
            end
        end
        if (c_valid) begin
            pulses2++;
            check("c_pulse_expected", 16'(q2.size() > 0), 16'd1);
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                check("c_bus", 16'(c_bus), 16'(e2.data));
                check("c_perr", 16'(c_perr), 16'(e2.perr));
                check("c_ferr", 16'(c_ferr), 16'(e2.ferr));
            end
        end
    end

    task automatic set_line(input int which, input logic v);
        case (which)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    function automatic logic get_active(input int which);
        case (which)
            0:       return a_active;
            1:       return b_active;
            default: return c_active;
        endcase
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int which, input exp_t e);
        case (which)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic drive_bit(input int which, input logic v);
        @(negedge clk);
        set_line(which, v);
        repeat (CPB - 1) @(negedge clk);
    endtask

    // One full frame; expected word is computed here and queued before driving
    task automatic send(input int which, input logic [8:0] data, input int nbits, input int par_mode,
                        input logic par_flip, input int nstop, input logic stop_val);
        logic [8:0] mask;
        logic [8:0] d;
        logic       par;
        exp_t       e;
        mask   = 9'((1 << nbits) - 1);
        d      = data & mask;
        par    = ^d;
        if (par_mode == 1) par = ~par;
        e.data = d;
        e.perr = (par_mode != 0) && par_flip;
        e.ferr = ~stop_val;
        push(which, e);
        drive_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i == 1) check("active_mid_frame", 16'(get_active(which)), 16'd1);
            drive_bit(which, d[i]);
        end
        if (par_mode != 0) drive_bit(which, par ^ par_flip);
        for (int i = 0; i < nstop; i++) drive_bit(which, (i == nstop - 1) ? stop_val : 1'b1);
    endtask

    task automatic wait_drain(input int which, input int budget);
        for (int i = 0; i < budget && qsize(which) != 0; i++) @(negedge clk);
        check("drain", 16'(qsize(which)), 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus", 16'(a_bus), 16'd0);
        check("rst_valid", 16'(a_valid), 16'd0);
        check("rst_active", 16'(a_active), 16'd0);
        check("rst_errs", 16'({a_perr, a_ferr, c_perr, c_ferr}), 16'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 8N1 0xA5
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
        wait_drain(0, 40);
        repeat (20) @(negedge clk);
        check("t1_active_after", 16'(a_active), 16'd0);
        check("t1_pulses", 16'(pulses0), 16'd1);

        // 2: even parity, bad then good parity bit
        send(1, 9'h003, 8, 2, 1'b1, 1, 1'b1);
        wait_drain(1, 40);
        repeat (10) @(negedge clk);
        check("t2_perr_hold", 16'(b_perr), 16'd1);
        send(1, 9'h003, 8, 2, 1'b0, 1, 1'b1);
        wait_drain(1, 40);
        repeat (10) @(negedge clk);
        check("t2_perr_clear", 16'(b_perr), 16'd0);
        check("t2_pulses", 16'(pulses1), 16'd2);

        // 3: 5-cycle glitch, then a real frame
        p = pulses0;
        @(negedge clk); rx0 = 1'b0;
        repeat (5) @(negedge clk);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        check("t3_active_glitch", 16'(a_active), 16'd0);
        check("t3_no_pulse", 16'(pulses0), 16'(p));
        send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1);
        wait_drain(0, 40);

        // 4: framing error followed by held-low break
        p = pulses0;
        send(0, 9'h000, 8, 0, 1'b0, 1, 1'b0);
        repeat (80) @(negedge clk);
        check("t4_one_pulse", 16'(pulses0), 16'(p + 1));
        check("t4_ferr_hold", 16'(a_ferr), 16'd1);
        rx0 = 1'b1;
        repeat (5) @(negedge clk);
        send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1);
        wait_drain(0, 40);
        repeat (10) @(negedge clk);
        check("t4_ferr_clear", 16'(a_ferr), 16'd0);

        // 5: reset mid-frame after 3 data bits of 0xFF
        p = pulses0;
        drive_bit(0, 1'b0);
        repeat (3) drive_bit(0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_bus", 16'(a_bus), 16'd0);
        check("t5_valid", 16'(a_valid), 16'd0);
        check("t5_active", 16'(a_active), 16'd0);
        check("t5_errs", 16'({a_perr, a_ferr}), 16'd0);
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("t5_no_pulse", 16'(pulses0), 16'(p));
        send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1);
        wait_drain(0, 40);

        // 6: 7O2 back-to-back
        send(2, 9'h041, 7, 1, 1'b0, 2, 1'b1);
        send(2, 9'h07F, 7, 1, 1'b0, 2, 1'b1);
        wait_drain(2, 40);
        repeat (20) @(negedge clk);
        check("t6_pulses", 16'(pulses2), 16'd2);
        check("t6_active_after", 16'(c_active), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
